// File: rtl/ariane_pkg.sv
// Shared core types. The writeback holding entry is also used by the issue logic.
package ariane_pkg;

    // Entry data is sized for the widest datapath. Narrower users keep only the low bits.
    localparam int unsigned WB_MAX_DATA_WIDTH = 64;

    typedef struct packed {
        logic                         valid;
        logic [4:0]                   addr;
        logic [WB_MAX_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/config_pkg.sv
// Core configuration slice. Only the fields that the writeback arbiter reads are defined here.
package config_pkg;

    typedef struct packed {
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

endpackage

// File: rtl/rr_multi_grant.sv
// Round-robin selector that grants up to NR_GNT requests per cycle.
// A request whose destination matches an already-granted one is skipped.
module rr_multi_grant #(
    parameter int unsigned  NR_REQ = 4,
    parameter int unsigned  NR_GNT = 2,
    localparam int unsigned IDX_W  = $clog2(NR_REQ)
) (
    input  logic [NR_REQ-1:0]             req_i,
    input  logic [NR_REQ-1:0][4:0]        addr_i,
    input  logic [IDX_W-1:0]              rr_i,
    output logic [NR_GNT-1:0][NR_REQ-1:0] gnt_o,
    output logic [NR_GNT-1:0][IDX_W-1:0]  idx_o,
    output logic [NR_GNT-1:0]             gnt_valid_o
);

    int unsigned       pos;
    logic [IDX_W-1:0]  cand;
    logic              blocked;
    logic [NR_REQ-1:0] taken;

    // Each port independently takes the first unblocked request in rotation order.
    // Earlier ports' picks are excluded, which gives the same result as one sequential scan.
    always_comb begin
        gnt_o       = '0;
        idx_o       = '0;
        gnt_valid_o = '0;
        taken       = '0;
        pos         = 0;
        cand        = '0;
        blocked     = 1'b0;
        for (int unsigned p = 0; p < NR_GNT; p++) begin
            for (int unsigned k = 0; k < NR_REQ; k++) begin
                pos = 32'(rr_i) + k;
                if (pos >= NR_REQ) pos = pos - NR_REQ;
                cand    = IDX_W'(pos);
                blocked = ~req_i[cand];
                for (int unsigned j = 0; j < NR_REQ; j++) begin
                    if (taken[j] && addr_i[j] == addr_i[cand]) blocked = 1'b1;
                end
                if (!gnt_valid_o[p] && !blocked) begin
                    gnt_valid_o[p]    = 1'b1;
                    gnt_o[p][cand]    = 1'b1;
                    idx_o[p]          = cand;
                end
            end
            taken = taken | gnt_o[p];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Buffers one result per functional unit and arbitrates the buffered results onto the regfile write ports.
module regfile_wb_arbiter
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           NR_SRC         = 4,
    localparam int unsigned          NR_WRITE_PORTS = CVA6Cfg.NrCommitPorts
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       flush_i,
    input  logic [NR_SRC-1:0]                          src_valid_i,
    output logic [NR_SRC-1:0]                          src_ready_o,
    input  logic [NR_SRC-1:0][4:0]                     src_waddr_i,
    input  logic [NR_SRC-1:0][DATA_WIDTH-1:0]          src_wdata_i,
    output logic [NR_WRITE_PORTS-1:0][4:0]             waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                  we_o,
    output logic [31:0]                                pending_o
);

    localparam int unsigned IDX_W = $clog2(NR_SRC);

    wb_entry_t                               entry_q [NR_SRC];
    wb_entry_t                               entry_d [NR_SRC];
    logic [IDX_W-1:0]                        rr_q, rr_d;
    logic [NR_SRC-1:0]                       req, granted;
    logic [NR_SRC-1:0][4:0]                  entry_addr;
    logic [NR_WRITE_PORTS-1:0][NR_SRC-1:0]   gnt;
    logic [NR_WRITE_PORTS-1:0][IDX_W-1:0]    gnt_idx;
    logic [NR_WRITE_PORTS-1:0]               gnt_valid;

    always_comb begin
        req        = '0;
        entry_addr = '0;
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            req[i]        = entry_q[i].valid & ~flush_i;
            entry_addr[i] = entry_q[i].addr;
        end
    end

    rr_multi_grant #(
        .NR_REQ (NR_SRC),
        .NR_GNT (NR_WRITE_PORTS)
    ) i_rr_multi_grant (
        .req_i       (req),
        .addr_i      (entry_addr),
        .rr_i        (rr_q),
        .gnt_o       (gnt),
        .idx_o       (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        granted = '0;
        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) granted = granted | gnt[p];
    end

    // Writes to x0 are always taken and dropped, even during a flush.
    always_comb begin
        src_ready_o = '0;
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            src_ready_o[i] = (src_waddr_i[i] == 5'd0) |
                             (~flush_i & (~entry_q[i].valid | granted[i]));
        end
    end

    always_comb begin
        entry_d = entry_q;
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            if (flush_i) begin
                entry_d[i].valid = 1'b0;
            end else if (src_valid_i[i] && src_ready_o[i] && src_waddr_i[i] != 5'd0) begin
                entry_d[i].valid = 1'b1;
                entry_d[i].addr  = src_waddr_i[i];
                entry_d[i].data  = WB_MAX_DATA_WIDTH'(src_wdata_i[i]);
            end else if (granted[i]) begin
                entry_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
            if (gnt_valid[p]) begin
                rr_d = (gnt_idx[p] == IDX_W'(NR_SRC - 1)) ? '0 : gnt_idx[p] + IDX_W'(1);
            end
        end
    end

    always_comb begin
        we_o    = '0;
        waddr_o = '0;
        wdata_o = '0;
        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
            if (gnt_valid[p]) begin
                we_o[p]    = 1'b1;
                waddr_o[p] = entry_q[gnt_idx[p]].addr;
                wdata_o[p] = entry_q[gnt_idx[p]].data[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            if (entry_q[i].valid) pending_o[entry_q[i].addr] = 1'b1;
        end
        pending_o[0] = 1'b0;
    end

    // Only the valid bits and the pointer are reset. The address and data fields are not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
            for (int unsigned i = 0; i < NR_SRC; i++) entry_q[i].valid <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter. It drives a two-write-port instance and a one-write-port instance.
module tb_regfile_wb_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;
    localparam config_pkg::cva6_cfg_t CFG2 = '{NrCommitPorts: 32'd2};
    localparam config_pkg::cva6_cfg_t CFG1 = '{NrCommitPorts: 32'd1};

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                   flush2, flush1;
    logic [NS-1:0]          v2, v1, rdy2, rdy1;
    logic [NS-1:0][4:0]     a2, a1;
    logic [NS-1:0][DW-1:0]  d2, d1;
    logic [1:0][4:0]        waddr2;
    logic [1:0][DW-1:0]     wdata2;
    logic [1:0]             we2;
    logic [0:0][4:0]        waddr1;
    logic [0:0][DW-1:0]     wdata1;
    logic [0:0]             we1;
    logic [31:0]            pend2, pend1;

    wr_t q2[$];
    wr_t q1[$];
    int  tests_run    = 0;
    int  tests_failed = 0;

    regfile_wb_arbiter #(.CVA6Cfg(CFG2), .DATA_WIDTH(DW), .NR_SRC(NS)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2),
        .src_valid_i(v2), .src_ready_o(rdy2), .src_waddr_i(a2), .src_wdata_i(d2),
        .waddr_o(waddr2), .wdata_o(wdata2), .we_o(we2), .pending_o(pend2)
    );

    regfile_wb_arbiter #(.CVA6Cfg(CFG1), .DATA_WIDTH(DW), .NR_SRC(NS)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1),
        .src_valid_i(v1), .src_ready_o(rdy1), .src_waddr_i(a1), .src_wdata_i(d1),
        .waddr_o(waddr1), .wdata_o(wdata1), .we_o(we1), .pending_o(pend1)
    );

    // Every regfile write must match the next expected write, in port order within a cycle.
    always @(negedge clk) begin : mon2
        wr_t e;
        for (int p = 0; p < 2; p++) begin
            if (we2[p] === 1'b1) begin
                tests_run++;
                if (q2.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wb2_unexpected_write port%0d: got addr=%0d data=%h, expected no write", p, waddr2[p], wdata2[p]);
                end else begin
                    e = q2.pop_front();
                    if (waddr2[p] !== e.addr || wdata2[p] !== e.data) begin
                        tests_failed++;
                        $display("FAIL wb2_write port%0d: got addr=%0d data=%h, expected addr=%0d data=%h", p, waddr2[p], wdata2[p], e.addr, e.data);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        wr_t e;
        if (we1[0] === 1'b1) begin
            tests_run++;
            if (q1.size() == 0) begin
                tests_failed++;
                $display("FAIL wb1_unexpected_write: got addr=%0d data=%h, expected no write", waddr1[0], wdata1[0]);
            end else begin
                e = q1.pop_front();
                if (waddr1[0] !== e.addr || wdata1[0] !== e.data) begin
                    tests_failed++;
                    $display("FAIL wb1_write: got addr=%0d data=%h, expected addr=%0d data=%h", waddr1[0], wdata1[0], e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if (rdy2 !== 4'hF) begin tests_failed++; $display("FAIL reset_ready2: got %b expected 1111", rdy2); end
        tests_run++;
        if (we2 !== 2'b00) begin tests_failed++; $display("FAIL reset_we2: got %b expected 00", we2); end
        tests_run++;
        if (waddr2 !== '0 || wdata2 !== '0) begin tests_failed++; $display("FAIL reset_wport2: got waddr=%h wdata=%h expected 0", waddr2, wdata2); end
        tests_run++;
        if (pend2 !== 32'h0) begin tests_failed++; $display("FAIL reset_pending2: got %h expected 0", pend2); end
        tests_run++;
        if (we1 !== 1'b0 || rdy1 !== 4'hF) begin tests_failed++; $display("FAIL reset_dut1: got we=%b rdy=%b expected we=0 rdy=1111", we1, rdy1); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_same_addr();
        v2 = 4'b0110; a2[1] = 5'd7; a2[2] = 5'd7; d2[1] = 32'h11; d2[2] = 32'h22;
        q2.push_back('{addr: 5'd7, data: 32'h11});
        q2.push_back('{addr: 5'd7, data: 32'h22});
        @(negedge clk);
        tests_run++;
        if (rdy2[2:1] !== 2'b11) begin tests_failed++; $display("FAIL same_addr_ready_empty: got %b expected 11", rdy2[2:1]); end
        tick();
        v2 = '0;
        @(negedge clk);
        tests_run++;
        if (we2 !== 2'b01 || waddr2[0] !== 5'd7 || wdata2[0] !== 32'h11) begin tests_failed++; $display("FAIL same_addr_c1: got we=%b addr=%0d data=%h expected we=01 addr=7 data=11", we2, waddr2[0], wdata2[0]); end
        tests_run++;
        if (pend2[7] !== 1'b1) begin tests_failed++; $display("FAIL same_addr_pending_c1: got %b expected 1", pend2[7]); end
        tests_run++;
        if (rdy2 !== 4'b1011) begin tests_failed++; $display("FAIL same_addr_ready_c1: got %b expected 1011", rdy2); end
        tick();
        @(negedge clk);
        tests_run++;
        if (we2 !== 2'b01 || waddr2[0] !== 5'd7 || wdata2[0] !== 32'h22) begin tests_failed++; $display("FAIL same_addr_c2: got we=%b addr=%0d data=%h expected we=01 addr=7 data=22", we2, waddr2[0], wdata2[0]); end
        tick();
        @(negedge clk);
        tests_run++;
        if (we2 !== 2'b00 || pend2 !== 32'h0) begin tests_failed++; $display("FAIL same_addr_idle: got we=%b pend=%h expected 00 / 0", we2, pend2); end
        tick();
    endtask

    task automatic test_dual_write();
        v2 = 4'b0011; a2[0] = 5'd5; a2[1] = 5'd6; d2[0] = 32'hA; d2[1] = 32'hB;
        q2.push_back('{addr: 5'd5, data: 32'hA});
        q2.push_back('{addr: 5'd6, data: 32'hB});
        tick();
        v2 = '0;
        @(negedge clk);
        tests_run++;
        if (we2 !== 2'b11) begin tests_failed++; $display("FAIL dual_we: got %b expected 11", we2); end
        tests_run++;
        if (waddr2 !== {5'd6, 5'd5} || wdata2 !== {32'hB, 32'hA}) begin tests_failed++; $display("FAIL dual_ports: got waddr=%h wdata=%h expected waddr=%h wdata=%h", waddr2, wdata2, {5'd6, 5'd5}, {32'hB, 32'hA}); end
        tests_run++;
        if (pend2 !== 32'h0000_0060) begin tests_failed++; $display("FAIL dual_pending: got %h expected 00000060", pend2); end
        tick();
        @(negedge clk);
        tests_run++;
        if (we2 !== 2'b00 || pend2 !== 32'h0) begin tests_failed++; $display("FAIL dual_idle: got we=%b pend=%h expected 00 / 0", we2, pend2); end
        tick();
    endtask

    task automatic test_zero_addr();
        v2 = 4'b1000; a2[3] = 5'd0; d2[3] = 32'hFFFF;
        @(negedge clk);
        tests_run++;
        if (rdy2[3] !== 1'b1) begin tests_failed++; $display("FAIL zero_ready: got %b expected 1", rdy2[3]); end
        tick();
        v2 = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (we2 !== 2'b00 || pend2 !== 32'h0) begin tests_failed++; $display("FAIL zero_no_write c%0d: got we=%b pend=%h expected 00 / 0", c, we2, pend2); end
            tick();
        end
    endtask

    task automatic test_flush();
        v2 = 4'b0011; a2 = '{5'd0, 5'd12, 5'd9, 5'd3}; d2[0] = 32'h33; d2[1] = 32'h99;
        tick();
        v2 = '0;
        flush2 = 1'b1;
        @(negedge clk);
        tests_run++;
        if (we2 !== 2'b00) begin tests_failed++; $display("FAIL flush_we: got %b expected 00", we2); end
        tests_run++;
        if (pend2 !== 32'h0000_0208) begin tests_failed++; $display("FAIL flush_pending_before: got %h expected 00000208", pend2); end
        tests_run++;
        if (rdy2 !== 4'b1000) begin tests_failed++; $display("FAIL flush_ready: got %b expected 1000", rdy2); end
        tick();
        flush2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (we2 !== 2'b00 || pend2 !== 32'h0) begin tests_failed++; $display("FAIL flush_after c%0d: got we=%b pend=%h expected 00 / 0", c, we2, pend2); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++) begin
            a1[k] = 5'(10 + k);
            d1[k] = 32'(256 + k);
        end
        for (int r = 0; r < 8; r++) q1.push_back('{addr: 5'(10 + r % 4), data: 32'(256 + r % 4)});
        v1 = 4'hF;
        @(negedge clk);
        tests_run++;
        if (rdy1 !== 4'hF) begin tests_failed++; $display("FAIL rr_ready_empty: got %b expected 1111", rdy1); end
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            tests_run++;
            if (we1 !== 1'b1 || waddr1[0] !== 5'(10 + c % 4)) begin tests_failed++; $display("FAIL rr_grant c%0d: got we=%b addr=%0d expected we=1 addr=%0d", c, we1, waddr1[0], 10 + c % 4); end
            tests_run++;
            if (rdy1 !== 4'(1 << (c % 4))) begin tests_failed++; $display("FAIL rr_ready c%0d: got %b expected %b", c, rdy1, 4'(1 << (c % 4))); end
        end
        v1 = '0;
        repeat (4) tick();
        @(negedge clk);
        tests_run++;
        if (we1 !== 1'b0 || pend1 !== 32'h0) begin tests_failed++; $display("FAIL rr_drained: got we=%b pend=%h expected 0 / 0", we1, pend1); end
        tick();
    endtask

    task automatic test_reset_mid();
        v2 = 4'b0111; a2 = '{5'd0, 5'd22, 5'd21, 5'd20}; d2 = '{32'h0, 32'h202, 32'h201, 32'h200};
        tick();
        v2 = '0;
        tests_run++;
        if (pend2 !== 32'h0070_0000) begin tests_failed++; $display("FAIL rstmid_pending_before: got %h expected 00700000", pend2); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (we2 !== 2'b00 || waddr2 !== '0 || wdata2 !== '0) begin tests_failed++; $display("FAIL rstmid_wport: got we=%b waddr=%h wdata=%h expected 0", we2, waddr2, wdata2); end
        tests_run++;
        if (rdy2 !== 4'hF || pend2 !== 32'h0) begin tests_failed++; $display("FAIL rstmid_state: got rdy=%b pend=%h expected 1111 / 0", rdy2, pend2); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (we2 !== 2'b00) begin tests_failed++; $display("FAIL rstmid_no_write c%0d: got %b expected 00", c, we2); end
            tick();
        end
        v2 = 4'b0001; a2[0] = 5'd23; d2[0] = 32'h77;
        q2.push_back('{addr: 5'd23, data: 32'h77});
        tick();
        v2 = '0;
        @(negedge clk);
        tests_run++;
        if (we2 !== 2'b01 || waddr2[0] !== 5'd23) begin tests_failed++; $display("FAIL rstmid_new_accept: got we=%b addr=%0d expected we=01 addr=23", we2, waddr2[0]); end
        tick();
    endtask

    task automatic test_drain();
        repeat (2) tick();
        tests_run++;
        if (q2.size() != 0) begin tests_failed++; $display("FAIL drain_q2: got %0d outstanding writes expected 0", q2.size()); end
        tests_run++;
        if (q1.size() != 0) begin tests_failed++; $display("FAIL drain_q1: got %0d outstanding writes expected 0", q1.size()); end
    endtask

    initial begin
        flush2 = 1'b0; flush1 = 1'b0;
        v2 = '0; a2 = '0; d2 = '0;
        v1 = '0; a1 = '0; d1 = '0;
        test_reset();
        test_same_addr();
        test_dual_write();
        test_zero_addr();
        test_flush();
        test_round_robin();
        test_reset_mid();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
